// File: rtl/im_fetch_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
// Holds the FSM state enum, width defaults and wait-counter width.
package im_fetch_pkg;

   localparam int unsigned DEF_ADDR_W   = 8;
   localparam int unsigned DEF_DATA_W   = 8;
   localparam int unsigned DEF_WAIT_CYC = 2;
   localparam int unsigned CNT_W        = 4;

   typedef enum logic [1:0] {
      S_WAIT   = 2'd0,
      S_SAMPLE = 2'd1,
      S_HALTED = 2'd2
   } fetch_state_t;

   // State entered whenever a fresh fetch starts: with no wait
   // cycles the data bus is sampled on the very next edge.
   function automatic fetch_state_t fetch_entry(int unsigned wc);
      return (wc == 0) ? S_SAMPLE : S_WAIT;
   endfunction

endpackage

// File: rtl/im_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, waits out memory latency,
// buffers one instruction for the decoder (valid/ready), redirect, halt.
// Ports: CLK, RST_N (sync, low) | ABUS, DATABUS memory side |
//        INSTR, INSTR_PC, INSTR_VALID, INSTR_READY decoder side |
//        REDIRECT, REDIRECT_PC, HALT control.
module im_fetch_ctrl
   import im_fetch_pkg::*;
#(
   parameter int unsigned WAIT_CYC = DEF_WAIT_CYC,
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned RESET_PC = 0
) (
   input  logic              CLK,
   input  logic              RST_N,
   output logic [ADDR_W-1:0] ABUS,
   input  logic [DATA_W-1:0] DATABUS,
   output logic [DATA_W-1:0] INSTR,
   output logic [ADDR_W-1:0] INSTR_PC,
   output logic              INSTR_VALID,
   input  logic              INSTR_READY,
   input  logic              REDIRECT,
   input  logic [ADDR_W-1:0] REDIRECT_PC,
   input  logic              HALT
);

   localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(WAIT_CYC);
   localparam logic [ADDR_W-1:0] PC_INIT  = ADDR_W'(RESET_PC);
   localparam fetch_state_t      ENTRY    = fetch_entry(WAIT_CYC);

   fetch_state_t      state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] instr_q, instr_d;
   logic [ADDR_W-1:0] ipc_q, ipc_d;
   logic              valid_q, valid_d;
   logic              take;
   logic              free;

   assign take = valid_q && INSTR_READY;
   assign free = !valid_q || INSTR_READY;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q <= ENTRY;
         cnt_q   <= CNT_INIT;
         pc_q    <= PC_INIT;
         instr_q <= '0;
         ipc_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         ipc_q   <= ipc_d;
         valid_q <= valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      ipc_d   = ipc_q;
      valid_d = valid_q;

      // A consumed entry empties the buffer unless refilled below.
      if (take) valid_d = 1'b0;

      unique case (state_q)
         S_WAIT: begin
            if (HALT) begin
               state_d = S_HALTED;
            end else begin
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == CNT_W'(1)) state_d = S_SAMPLE;
            end
         end
         S_SAMPLE: begin
            if (HALT) begin
               state_d = S_HALTED;
            end else if (free) begin
               instr_d = DATABUS;
               ipc_d   = pc_q;
               valid_d = 1'b1;
               pc_d    = pc_q + 1'b1;
               cnt_d   = CNT_INIT;
               state_d = ENTRY;
            end
         end
         S_HALTED: begin
            // Counter restarts so the held PC is refetched in full.
            if (!HALT) begin
               cnt_d   = CNT_INIT;
               state_d = ENTRY;
            end
         end
         default: begin
            cnt_d   = CNT_INIT;
            state_d = ENTRY;
         end
      endcase

      // Redirect overrides the above; the buffered word and any
      // capture on this edge are dropped, halt status is kept.
      if (REDIRECT) begin
         pc_d    = REDIRECT_PC;
         cnt_d   = CNT_INIT;
         valid_d = 1'b0;
         instr_d = instr_q;
         ipc_d   = ipc_q;
         state_d = (state_q == S_HALTED) ? S_HALTED : ENTRY;
      end
   end

   assign ABUS        = pc_q;
   assign INSTR       = instr_q;
   assign INSTR_PC    = ipc_q;
   assign INSTR_VALID = valid_q;

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// Bench for im_fetch_ctrl: WAIT_CYC=2 and WAIT_CYC=0 instances driven
// together and compared every cycle against a timing-level model.
module tb_im_fetch_ctrl;

   typedef struct packed {
      logic [7:0] pc;
      logic [4:0] age;
      logic       halted;
      logic       valid;
      logic [7:0] instr;
      logic [7:0] ipc;
   } mdl_t;

   logic       clk;
   logic       rst_n;
   logic       ready;
   logic       redir;
   logic [7:0] rpc;
   logic       halt;

   logic [7:0] mem [256];

   logic [7:0] abus2, db2, instr2, ipc2;
   logic       valid2;
   logic [7:0] abus0, db0, instr0, ipc0;
   logic       valid0;

   int checks;
   int failures;

   mdl_t m2;
   mdl_t m0;

   assign db2 = mem[abus2];
   assign db0 = mem[abus0];

   im_fetch_ctrl #(
      .WAIT_CYC(2), .ADDR_W(8), .DATA_W(8), .RESET_PC(0)
   ) u_dut2 (
      .CLK(clk), .RST_N(rst_n), .ABUS(abus2), .DATABUS(db2),
      .INSTR(instr2), .INSTR_PC(ipc2), .INSTR_VALID(valid2),
      .INSTR_READY(ready), .REDIRECT(redir), .REDIRECT_PC(rpc),
      .HALT(halt)
   );

   im_fetch_ctrl #(
      .WAIT_CYC(0), .ADDR_W(8), .DATA_W(8), .RESET_PC(0)
   ) u_dut0 (
      .CLK(clk), .RST_N(rst_n), .ABUS(abus0), .DATABUS(db0),
      .INSTR(instr0), .INSTR_PC(ipc0), .INSTR_VALID(valid0),
      .INSTR_READY(ready), .REDIRECT(redir), .REDIRECT_PC(rpc),
      .HALT(halt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got,
                      input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // age = edges since the current address was presented;
   // a capture may happen once age has reached the wait count.
   function automatic mdl_t step(mdl_t m, int wc, logic rn,
                                 logic rdy, logic rd,
                                 logic [7:0] rp, logic h);
      mdl_t n;
      logic tk;
      n  = m;
      tk = m.valid && rdy;
      if (!rn) begin
         n = '0;
         return n;
      end
      if (rd) begin
         n.pc    = rp;
         n.age   = '0;
         n.valid = 1'b0;
         return n;
      end
      if (tk) n.valid = 1'b0;
      if (m.halted) begin
         if (!h) begin
            n.halted = 1'b0;
            n.age    = '0;
         end
         return n;
      end
      if (h) begin
         n.halted = 1'b1;
         return n;
      end
      if (int'(m.age) >= wc && (!m.valid || rdy)) begin
         n.instr = mem[m.pc];
         n.ipc   = m.pc;
         n.valid = 1'b1;
         n.pc    = m.pc + 8'd1;
         n.age   = '0;
      end else if (int'(m.age) < wc) begin
         n.age = m.age + 5'd1;
      end
      return n;
   endfunction

   task automatic cycle();
      @(posedge clk);
      m2 = step(m2, 2, rst_n, ready, redir, rpc, halt);
      m0 = step(m0, 0, rst_n, ready, redir, rpc, halt);
      #1;
      chk("abus2",  abus2,      m2.pc);
      chk("valid2", 8'(valid2), 8'(m2.valid));
      chk("abus0",  abus0,      m0.pc);
      chk("valid0", 8'(valid0), 8'(m0.valid));
      if (m2.valid) begin
         chk("instr2", instr2, m2.instr);
         chk("ipc2",   ipc2,   m2.ipc);
      end
      if (m0.valid) begin
         chk("instr0", instr0, m0.instr);
         chk("ipc0",   ipc0,   m0.ipc);
      end
      @(negedge clk);
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      m2       = '0;
      m0       = '0;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      mem[0] = 8'hA0;
      mem[1] = 8'hA1;
      mem[2] = 8'hA2;
      mem[3] = 8'hA3;
      rst_n = 1'b0;
      ready = 1'b1;
      redir = 1'b0;
      rpc   = 8'h00;
      halt  = 1'b0;

      // reset
      cycle();
      chk("rst_valid", 8'(valid2), 8'h00);
      chk("rst_abus",  abus2,      8'h00);
      chk("rst_instr", instr2,     8'h00);
      chk("rst_ipc",   ipc2,       8'h00);

      // first capture at edge WAIT_CYC+1, then back-pressure
      rst_n = 1'b1;
      cycles(2);
      chk("pre_valid", 8'(valid2), 8'h00);
      cycle();
      chk("first_valid", 8'(valid2), 8'h01);
      chk("first_instr", instr2,     8'hA0);
      chk("first_ipc",   ipc2,       8'h00);
      chk("wc0_instr",   instr0,     8'hA2);
      chk("wc0_ipc",     ipc0,       8'h02);
      ready = 1'b0;
      cycles(5);
      chk("stall_instr", instr2,     8'hA0);
      chk("stall_valid", 8'(valid2), 8'h01);
      chk("stall_abus",  abus2,      8'h01);
      chk("stall0",      instr0,     8'hA2);
      ready = 1'b1;
      cycle();
      chk("resume_instr", instr2, 8'hA1);
      chk("resume_ipc",   ipc2,   8'h01);
      chk("resume0",      instr0, 8'hA3);
      cycles(3);
      chk("third_instr", instr2, 8'hA2);

      // PC wrap
      rpc   = 8'hFF;
      redir = 1'b1;
      cycle();
      redir = 1'b0;
      cycles(3);
      chk("wrap_ipc",  ipc2,  8'hFF);
      chk("wrap_abus", abus2, 8'h00);
      cycles(3);
      chk("wrap_instr", instr2, 8'hA0);

      // redirect while buffer valid and in WAIT
      rpc   = 8'h40;
      redir = 1'b1;
      ready = 1'b0;
      cycle();
      chk("redir_valid", 8'(valid2), 8'h00);
      chk("redir_abus",  abus2,      8'h40);
      redir = 1'b0;
      ready = 1'b1;
      cycles(2);
      chk("redir_nostale", 8'(valid2), 8'h00);
      cycle();
      chk("redir_instr", instr2, mem[8'h40]);
      chk("redir_ipc",   ipc2,   8'h40);

      // halt mid-WAIT
      cycle();
      halt = 1'b1;
      cycles(4);
      chk("halt_valid", 8'(valid2), 8'h00);
      chk("halt_abus",  abus2,      8'h41);
      halt = 1'b0;
      cycles(3);
      chk("unhalt_wait", 8'(valid2), 8'h00);
      cycle();
      chk("unhalt_instr", instr2, mem[8'h41]);
      chk("unhalt_ipc",   ipc2,   8'h41);

      // reset during a stall
      ready = 1'b0;
      cycles(4);
      rst_n = 1'b0;
      cycle();
      chk("rst2_valid", 8'(valid2), 8'h00);
      chk("rst2_abus",  abus2,      8'h00);
      chk("rst2_instr", instr2,     8'h00);
      rst_n = 1'b1;

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rst_n = ($urandom_range(0, 199) != 0);
         ready = ($urandom_range(0, 99) < 70);
         redir = ($urandom_range(0, 99) < 4);
         rpc   = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
         if ($urandom_range(0, 99) < 6) halt = !halt;
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
